// File: rtl/done_receiver.sv
// done_receiver
// Launches one CPU command per host request and classifies the completion
// pulse width that comes back on prog_done:
//   1 high cycle  -> ok (00)
//   2 high cycles -> command error (01)
//   no pulse within TIMEOUT_CYCLES WAIT cycles -> timeout (10)
//   3 or more high cycles -> protocol violation (11)
// The result is held on rsp_valid/rsp_status until the host takes it.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid    host requests one command launch
//   req_ready    block can accept a request (IDLE only)
//   cmd_start    single-cycle launch pulse to the CPU command path
//   prog_done    completion pulse from the CPU
//   rsp_valid    response available
//   rsp_ready    host consumes the response
//   rsp_status   00 ok, 01 cmd error, 10 timeout, 11 protocol violation
//   spurious_err sticky: prog_done rose while no completion was expected
//   ok_count     saturating count of ok responses
//   err_count    saturating count of non-ok responses
module done_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             cmd_start,
  input  logic             prog_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_status,
  output logic             spurious_err,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    PULSE,
    RESP
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;
  localparam logic [1:0] ST_VIO = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [1:0]       width;
  logic             prog_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      cmd_start    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_status   <= ST_OK;
      spurious_err <= 1'b0;
      ok_count     <= '0;
      err_count    <= '0;
      tmo_cnt      <= '0;
      width        <= 2'd0;
      prog_done_q  <= 1'b0;
    end else begin
      prog_done_q <= prog_done;

      // Only a rising edge counts, so a level left over from a violation
      // exit never flags; the state machine ignores it either way.
      if (prog_done && !prog_done_q &&
          (state == IDLE || state == START || state == RESP))
        spurious_err <= 1'b1;

      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= START;
            req_ready <= 1'b0;
            cmd_start <= 1'b1;
          end
        end

        START: begin
          cmd_start <= 1'b0;
          tmo_cnt   <= '0;
          width     <= 2'd0;
          state     <= WAIT;
        end

        WAIT: begin
          // A completion on the expiry cycle wins over the timeout.
          if (prog_done) begin
            width <= 2'd1;
            state <= PULSE;
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_status <= ST_TMO;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        PULSE: begin
          if (!prog_done) begin
            rsp_status <= (width == 2'd2) ? ST_ERR : ST_OK;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (width == 2'd1) begin
            width <= 2'd2;
          end else begin
            rsp_status <= ST_VIO;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
            if (rsp_status == ST_OK) begin
              if (ok_count != '1) ok_count <= ok_count + 1'b1;
            end else begin
              if (err_count != '1) err_count <= err_count + 1'b1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          cmd_start <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
